atm_keypad_frontend: RTL
========================

Name: atm_keypad_frontend

Overview:
Customer-side front end for the ATM core. It turns a stream of keypad key codes into complete, validated requests: account number, PIN, menu option, destination account and amount. Each request goes to the ATM core over a valid/ready handshake, and the block then waits for the core's error/balance response. It also owns inactivity timeout, cancel handling and lockout after repeated authentication failures.

Parameters:
TIMEOUT_CYCLES, 1000, idle cycles allowed in any entry state before a forced exit.
MAX_TRIES, 3, consecutive authentication failures that trigger lockout.
LOCK_CYCLES, 500, cycles spent in LOCKED before returning to ACC_ENTRY.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
key_valid  in  1  one-cycle strobe; key_code is valid when high.
key_code  in  4  0-9 digit, 4'hA ENTER, 4'hB CLEAR, 4'hC CANCEL; 4'hD-F ignored.
accNumber  out  12  entered account number (binary).
pin  out  4  entered PIN digit.
destinationAcc  out  12  destination account for option 6.
menuOption  out  3  selected option: 3 balance, 4 withdraw, 5 withdraw+show, 6 transfer, 7 deposit.
amount  out  11  entered amount.
req_valid  out  1  request valid to the ATM core.
req_auth  out  1  1 = authentication request, 0 = transaction request.
req_ready  in  1  core accepts the request.
resp_valid  in  1  one-cycle response strobe from the core.
resp_error  in  1  response error flag.
resp_balance  in  11  balance returned with the response.
exit  out  1  one-cycle pulse: session terminated (cancel or timeout).
entry_error  out  1  one-cycle pulse: invalid key entry.
last_error  out  1  registered resp_error of the last response.
last_balance  out  11  registered resp_balance of the last response.
state  out  4  current FSM state code.

Behaviour:
- Reset: all outputs 0, state ACC_ENTRY (0). Digit counter, accumulator, fail counter and timer cleared. rst overrides every other input in the same cycle.
- States: ACC_ENTRY=0, PIN_ENTRY=1, AUTH_SEND=2, AUTH_WAIT=3, MENU_ENTRY=4, DEST_ENTRY=5, AMOUNT_ENTRY=6, TXN_SEND=7, TXN_WAIT=8, LOCKED=9.
- Digit entry: on each digit, accumulator = accumulator*10 + digit, using a 14-bit internal width. Maximum digits: account and destination 4, PIN 1, option 1, amount 4. A digit beyond the maximum is dropped and pulses entry_error.
- CLEAR: zeroes the current field's accumulator and digit count. State is unchanged.
- ENTER:
  - With zero digits: entry_error pulse, no state change.
  - Account field: value must be <=4095, else entry_error and the field is cleared.
  - Amount field: value must be <=2047, else entry_error and the field is cleared.
  - Option field: values 0-2 give entry_error.
  - Otherwise the field is latched onto its output port and the FSM advances.
- Transitions:
  - ACC_ENTRY -> PIN_ENTRY -> AUTH_SEND.
  - MENU_ENTRY: option 3 -> TXN_SEND; 4, 5, 7 -> AMOUNT_ENTRY; 6 -> DEST_ENTRY -> AMOUNT_ENTRY -> TXN_SEND.
- Handshake:
  - req_valid rises on entry to AUTH_SEND or TXN_SEND.
  - req_valid and all request fields are held stable until the cycle where req_valid && req_ready. The next state is then AUTH_WAIT or TXN_WAIT and req_valid drops.
  - req_auth = 1 in AUTH_SEND, 0 in TXN_SEND.
- Response handling: on resp_valid in a WAIT state, register last_error and last_balance. resp_valid outside a WAIT state is ignored.
- AUTH_WAIT outcome:
  - resp_error=0: clear the fail counter, go to MENU_ENTRY.
  - resp_error=1: increment the fail counter and clear accNumber/pin. If the count reaches MAX_TRIES go to LOCKED, else ACC_ENTRY.
- TXN_WAIT: on response, go to MENU_ENTRY; amount and destinationAcc are cleared.
- LOCKED:
  - All keys ignored.
  - After exactly LOCK_CYCLES cycles, return to ACC_ENTRY and clear the fail counter.
  - CANCEL does not shorten the lockout.
- Inactivity timer:
  - Counts only in ACC_ENTRY (when a field holds at least one digit), PIN_ENTRY, MENU_ENTRY, DEST_ENTRY and AMOUNT_ENTRY.
  - Any key_valid with codes 0-C reloads it; codes D-F never reload it.
  - On reaching TIMEOUT_CYCLES: exit pulse, all fields cleared, go to ACC_ENTRY.
- CANCEL in any entry state: exit pulse next cycle, all fields cleared, go to ACC_ENTRY.
  - The fail counter is not cleared by cancel or timeout.
  - Keys, including CANCEL, in SEND/WAIT states are ignored; the transaction always completes.
- Simultaneous timeout and key in the same cycle: the key wins and the timer reloads.

Test Plan:
- Keys 2,1,7,5,ENTER,1,ENTER; req_ready held low 3 cycles -> req_valid=1, req_auth=1, accNumber=2175, pin=1 stable for all 4 cycles; req_valid drops after acceptance; resp_error=0 -> state=4.
- From MENU: keys 4,ENTER,2,0,0,ENTER -> req with menuOption=4, amount=200, req_auth=0; resp_balance=300 -> last_balance=300, state=4.
- Keys 5,0,0,0,ENTER in ACC_ENTRY -> entry_error pulse, accNumber=0, state=0; amount entry 2,0,4,8,ENTER -> entry_error.
- Three auth attempts each answered resp_error=1 -> state=9; keys ignored for 500 cycles; then state=0.
- Option 6, destination 2,4,2,9, amount 1,0,0 -> destinationAcc=2429, amount=100, menuOption=6.
- In MENU_ENTRY, no key for 1000 cycles -> exit pulse, state=0, all fields 0; CANCEL while state=8 -> no exit pulse.

Source files
------------

// File: rtl/atm_keypad_frontend.sv
// ATM customer front end: keypad field entry, request handshake to the core,
// inactivity timeout and lockout after repeated authentication failures.
module atm_keypad_frontend #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_TRIES      = 3,
    parameter int LOCK_CYCLES    = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [11:0] accNumber,
    output logic [3:0]  pin,
    output logic [11:0] destinationAcc,
    output logic [2:0]  menuOption,
    output logic [10:0] amount,
    output logic        req_valid,
    output logic        req_auth,
    input  logic        req_ready,
    input  logic        resp_valid,
    input  logic        resp_error,
    input  logic [10:0] resp_balance,
    output logic        exit,
    output logic        entry_error,
    output logic        last_error,
    output logic [10:0] last_balance,
    output logic [3:0]  state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0] LK_LAST   = LW'(LOCK_CYCLES - 1);
    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_TRIES - 1);

    typedef enum logic [3:0] {
        S_ACC       = 4'd0,
        S_PIN       = 4'd1,
        S_AUTH_SEND = 4'd2,
        S_AUTH_WAIT = 4'd3,
        S_MENU      = 4'd4,
        S_DEST      = 4'd5,
        S_AMT       = 4'd6,
        S_TXN_SEND  = 4'd7,
        S_TXN_WAIT  = 4'd8,
        S_LOCKED    = 4'd9
    } state_t;

    state_t          state_q;
    state_t          state_d;
    state_t          adv_state;
    logic [13:0]     acc_q;
    logic [13:0]     acc_mac;
    logic [2:0]      cnt_q;
    logic [2:0]      max_dig;
    logic [TW-1:0]   timer_q;
    logic [LW-1:0]   lock_q;
    logic [FW-1:0]   fail_q;

    logic is_digit;
    logic is_enter;
    logic is_clear;
    logic is_cancel;
    logic live_key;
    logic entry_st;
    logic timer_run;
    logic timeout;
    logic field_ok;

    logic f_push;
    logic f_err;
    logic f_fclear;
    logic f_latch;
    logic f_wipe;
    logic f_resp;
    logic f_auth_ok;
    logic f_auth_fail;
    logic f_txn_done;
    logic f_lock_done;

    // Key decode and per-field limits for the field currently being entered
    always_comb begin
        is_digit  = key_valid && (key_code <= 4'd9);
        is_enter  = key_valid && (key_code == 4'hA);
        is_clear  = key_valid && (key_code == 4'hB);
        is_cancel = key_valid && (key_code == 4'hC);
        live_key  = key_valid && (key_code <= 4'hC);
        entry_st  = (state_q == S_ACC) || (state_q == S_PIN) ||
                    (state_q == S_MENU) || (state_q == S_DEST) ||
                    (state_q == S_AMT);
        // An empty account field is the idle screen: no timeout there
        timer_run = entry_st &&
                    !((state_q == S_ACC) && (cnt_q == 3'd0));
        timeout   = timer_run && !live_key && (timer_q == TO_LAST);
        acc_mac   = acc_q * 14'd10 + {10'd0, key_code};
        max_dig   = ((state_q == S_PIN) || (state_q == S_MENU)) ?
                    3'd1 : 3'd4;
        field_ok  = 1'b1;
        adv_state = state_q;
        unique case (state_q)
            S_ACC: begin
                field_ok  = acc_q <= 14'd4095;
                adv_state = S_PIN;
            end
            S_PIN: adv_state = S_AUTH_SEND;
            S_MENU: begin
                field_ok  = (acc_q >= 14'd3) && (acc_q <= 14'd7);
                adv_state = (acc_q == 14'd3) ? S_TXN_SEND :
                            (acc_q == 14'd6) ? S_DEST : S_AMT;
            end
            S_DEST: begin
                field_ok  = acc_q <= 14'd4095;
                adv_state = S_AMT;
            end
            S_AMT: begin
                field_ok  = acc_q <= 14'd2047;
                adv_state = S_TXN_SEND;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_ACC;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        f_push      = 1'b0;
        f_err       = 1'b0;
        f_fclear    = 1'b0;
        f_latch     = 1'b0;
        f_wipe      = 1'b0;
        f_resp      = 1'b0;
        f_auth_ok   = 1'b0;
        f_auth_fail = 1'b0;
        f_txn_done  = 1'b0;
        f_lock_done = 1'b0;
        unique case (state_q)
            S_ACC, S_PIN, S_MENU, S_DEST, S_AMT: begin
                unique case (1'b1)
                    is_cancel: begin
                        f_wipe  = 1'b1;
                        state_d = S_ACC;
                    end
                    is_clear: f_fclear = 1'b1;
                    is_digit: begin
                        if (cnt_q == max_dig) f_err  = 1'b1;
                        else                  f_push = 1'b1;
                    end
                    is_enter: begin
                        if (cnt_q == 3'd0) begin
                            f_err = 1'b1;
                        end else if (!field_ok) begin
                            f_err    = 1'b1;
                            f_fclear = 1'b1;
                        end else begin
                            f_latch = 1'b1;
                            state_d = adv_state;
                        end
                    end
                    timeout: begin
                        f_wipe  = 1'b1;
                        state_d = S_ACC;
                    end
                    default: ;
                endcase
            end
            S_AUTH_SEND: if (req_ready) state_d = S_AUTH_WAIT;
            S_TXN_SEND:  if (req_ready) state_d = S_TXN_WAIT;
            S_AUTH_WAIT: begin
                if (resp_valid) begin
                    f_resp = 1'b1;
                    if (resp_error) begin
                        f_auth_fail = 1'b1;
                        state_d = (fail_q >= FAIL_LAST) ?
                                  S_LOCKED : S_ACC;
                    end else begin
                        f_auth_ok = 1'b1;
                        state_d   = S_MENU;
                    end
                end
            end
            S_TXN_WAIT: begin
                if (resp_valid) begin
                    f_resp     = 1'b1;
                    f_txn_done = 1'b1;
                    state_d    = S_MENU;
                end
            end
            S_LOCKED: begin
                if (lock_q == LK_LAST) begin
                    f_lock_done = 1'b1;
                    state_d     = S_ACC;
                end
            end
            default: state_d = S_ACC;
        endcase
    end

    always_comb begin
        req_valid = (state_q == S_AUTH_SEND) || (state_q == S_TXN_SEND);
        req_auth  = (state_q == S_AUTH_SEND);
        state     = state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q          <= '0;
            cnt_q          <= '0;
            timer_q        <= '0;
            lock_q         <= '0;
            fail_q         <= '0;
            accNumber      <= '0;
            pin            <= '0;
            destinationAcc <= '0;
            menuOption     <= '0;
            amount         <= '0;
            exit           <= 1'b0;
            entry_error    <= 1'b0;
            last_error     <= 1'b0;
            last_balance   <= '0;
        end else begin
            exit        <= f_wipe;
            entry_error <= f_err;
            if (f_push) begin
                acc_q <= acc_mac;
                cnt_q <= cnt_q + 3'd1;
            end
            if (f_fclear || f_latch || f_wipe) begin
                acc_q <= '0;
                cnt_q <= '0;
            end
            if (f_latch) begin
                unique case (state_q)
                    S_ACC:   accNumber      <= acc_q[11:0];
                    S_PIN:   pin            <= acc_q[3:0];
                    S_MENU:  menuOption     <= acc_q[2:0];
                    S_DEST:  destinationAcc <= acc_q[11:0];
                    S_AMT:   amount         <= acc_q[10:0];
                    default: ;
                endcase
            end
            if (f_wipe) begin
                accNumber      <= '0;
                pin            <= '0;
                destinationAcc <= '0;
                menuOption     <= '0;
                amount         <= '0;
            end
            if (f_resp) begin
                last_error   <= resp_error;
                last_balance <= resp_balance;
            end
            if (f_auth_fail) begin
                fail_q    <= fail_q + FW'(1);
                accNumber <= '0;
                pin       <= '0;
            end
            if (f_auth_ok || f_lock_done) fail_q <= '0;
            if (f_txn_done) begin
                amount         <= '0;
                destinationAcc <= '0;
            end
            if (!timer_run || live_key || timeout) timer_q <= '0;
            else                                   timer_q <= timer_q + TW'(1);
            if (state_q == S_LOCKED && !f_lock_done) lock_q <= lock_q + LW'(1);
            else                                     lock_q <= '0;
        end
    end

endmodule
